// File: rtl/irq_ctrl_if.sv
// Register bus between the Bridge and the interrupt controller.
// Word-addressed, single-cycle writes, combinational reads.
interface irq_ctrl_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (
    output Addr,
    output WE,
    output Din,
    input  Dout
  );

  modport slave (
    input  Addr,
    input  WE,
    input  Din,
    output Dout
  );
endinterface

// File: rtl/irq_ctrl.sv
// Prioritised, nesting interrupt controller in front of the CPU HWInt line.
// Index 0 is the highest priority; vec/STAT expose the winning source.
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] src,
  output logic             irq,
  output logic [3:0]       vec
);

  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] ins;
  logic [N_SRC-1:0] src_d;

  logic [N_SRC-1:0] eff;
  logic [N_SRC-1:0] vec_oh;
  logic [N_SRC-1:0] edge_keep;
  logic [N_SRC-1:0] pend_n;
  logic [N_SRC-1:0] ins_n;
  logic [4:0]       cur;
  logic             valid;
  logic             irq_n;
  logic             claim_ok;
  logic             wr_mask;
  logic             wr_mode;
  logic             wr_pend;
  logic             wr_cmd;

  assign eff    = pend & mask;
  assign valid  = |eff;
  assign vec_oh = eff & (~eff + N_SRC'(1));

  always_comb begin
    vec = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eff[i]) vec = 4'(i);
    end
  end

  always_comb begin
    cur = 5'(N_SRC);
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (ins[i]) cur = 5'(i);
    end
  end

  assign irq_n = valid && ({1'b0, vec} < cur);

  always_comb begin
    wr_mask = 1'b0;
    wr_mode = 1'b0;
    wr_pend = 1'b0;
    wr_cmd  = 1'b0;
    if (bus.WE) begin
      unique case (bus.Addr)
        2'd0: wr_mask = 1'b1;
        2'd1: wr_mode = 1'b1;
        2'd2: wr_pend = 1'b1;
        2'd3: wr_cmd  = 1'b1;
      endcase
    end
  end

  assign claim_ok = wr_cmd && bus.Din[0] && valid;

  // Clears first, new edges OR-ed in last so a fresh edge is never lost.
  always_comb begin
    edge_keep = pend;
    if (wr_pend) edge_keep = edge_keep & ~bus.Din[N_SRC-1:0];
    if (claim_ok) edge_keep = edge_keep & ~vec_oh;
    edge_keep = edge_keep | (src & ~src_d);
    pend_n = (mode & edge_keep) | (~mode & src);
  end

  // EOI acts on the old INS, then CLAIM adds the pre-write winner.
  always_comb begin
    ins_n = ins;
    if (wr_cmd && bus.Din[1]) ins_n = ins & (ins - N_SRC'(1));
    if (claim_ok) ins_n = ins_n | vec_oh;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask  <= '0;
      mode  <= '0;
      pend  <= '0;
      ins   <= '0;
      src_d <= '0;
      irq   <= 1'b0;
    end else begin
      if (wr_mask) mask <= bus.Din[N_SRC-1:0];
      if (wr_mode) mode <= bus.Din[N_SRC-1:0];
      pend  <= pend_n;
      ins   <= ins_n;
      src_d <= src;
      irq   <= irq_n;
    end
  end

  always_comb begin
    bus.Dout = '0;
    unique case (bus.Addr)
      2'd0: bus.Dout[N_SRC-1:0] = mask;
      2'd1: bus.Dout[N_SRC-1:0] = mode;
      2'd2: bus.Dout[N_SRC-1:0] = pend;
      2'd3: begin
        bus.Dout[31]      = valid;
        bus.Dout[19:16]   = vec;
        bus.Dout[N_SRC-1:0] = ins;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: vector table plus reset and
// same-cycle corner sequences.
module tb_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] src;
  logic       irq;
  logic [3:0] vec;

  int n_chk;
  int n_fail;

  irq_ctrl_if bus ();

  irq_ctrl #(
    .N_SRC (6)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave),
    .src   (src),
    .irq   (irq),
    .vec   (vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [5:0]  s;
    logic [1:0]  ra;
    logic [31:0] dout;
    bit          irq;
    logic [3:0]  vec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit wr, logic [1:0] wa, logic [31:0] wd,
                              logic [5:0] s, logic [1:0] ra,
                              logic [31:0] d, bit q, logic [3:0] v);
    vec_t t;
    t.wr = wr; t.wa = wa; t.wd = wd; t.s = s; t.ra = ra;
    t.dout = d; t.irq = q; t.vec = v;
    tbl.push_back(t);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic step(bit wr, logic [1:0] wa, logic [31:0] wd,
                      logic [5:0] s, logic [1:0] ra);
    @(negedge clk);
    src      = s;
    bus.Addr = wa;
    bus.WE   = wr;
    bus.Din  = wd;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
    bus.Addr = ra;
    #1;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    src      = '0;
    bus.Addr = 2'd0;
    bus.WE   = 1'b0;
    bus.Din  = '0;

    // level source, claim, EOI with source still high
    add(1,0,32'h3F,6'h00,2, 32'h00000000,0,0);
    tbl[0].ra = 0; tbl[0].dout = 32'h3F;
    add(0,0,0,6'h04,2, 32'h00000004,0,2);
    add(0,0,0,6'h04,3, 32'h80020000,1,2);
    add(1,3,1,6'h04,3, 32'h80020004,1,2);
    add(0,0,0,6'h04,3, 32'h80020004,0,2);
    add(1,3,2,6'h04,3, 32'h80020000,0,2);
    add(0,0,0,6'h04,3, 32'h80020000,1,2);
    add(0,0,0,6'h00,2, 32'h00000000,1,0);
    add(0,0,0,6'h00,2, 32'h00000000,0,0);
    // edge source, claim, re-pulse at equal priority
    add(1,1,1,6'h00,1, 32'h00000001,0,0);
    add(0,0,0,6'h01,2, 32'h00000001,0,0);
    add(0,0,0,6'h00,2, 32'h00000001,1,0);
    add(0,0,0,6'h00,2, 32'h00000001,1,0);
    add(1,3,1,6'h00,3, 32'h00000001,1,0);
    add(0,0,0,6'h00,2, 32'h00000000,0,0);
    add(0,0,0,6'h01,2, 32'h00000001,0,0);
    add(0,0,0,6'h00,2, 32'h00000001,0,0);
    add(0,0,0,6'h00,3, 32'h80000001,0,0);
    add(1,2,1,6'h00,2, 32'h00000000,0,0);
    add(1,3,2,6'h00,3, 32'h00000000,0,0);
    // nesting
    add(0,0,0,6'h08,2, 32'h00000008,0,3);
    add(0,0,0,6'h08,3, 32'h80030000,1,3);
    add(1,3,1,6'h08,3, 32'h80030008,1,3);
    add(0,0,0,6'h08,3, 32'h80030008,0,3);
    add(0,0,0,6'h0A,2, 32'h0000000A,0,1);
    add(0,0,0,6'h0A,3, 32'h80010008,1,1);
    add(1,3,1,6'h0A,3, 32'h8001000A,1,1);
    add(0,0,0,6'h0A,3, 32'h8001000A,0,1);
    add(1,3,2,6'h0A,3, 32'h80010008,0,1);
    add(0,0,0,6'h0A,3, 32'h80010008,1,1);
    add(1,3,2,6'h00,3, 32'h00000000,1,0);
    add(0,0,0,6'h00,3, 32'h00000000,0,0);
    // masking
    add(1,0,2,6'h05,2, 32'h00000005,0,0);
    add(0,0,0,6'h05,3, 32'h00000000,0,0);
    add(1,0,5,6'h05,3, 32'h80000000,0,0);
    add(0,0,0,6'h05,3, 32'h80000000,1,0);
    add(1,3,1,6'h05,3, 32'h80020001,1,2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int a = 0; a < 4; a++) begin
      bus.Addr = 2'(a);
      #1;
      chk($sformatf("rst dout a%0d", a), bus.Dout, 32'h0);
    end
    chk("rst irq", {31'b0, irq}, 32'h0);
    chk("rst vec", {28'b0, vec}, 32'h0);

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].s, tbl[i].ra);
      chk($sformatf("v%0d dout", i), bus.Dout, tbl[i].dout);
      chk($sformatf("v%0d irq", i), {31'b0, irq}, {31'b0, tbl[i].irq});
      chk($sformatf("v%0d vec", i), {28'b0, vec}, {28'b0, tbl[i].vec});
    end

    // asynchronous reset mid-run with PEND/INS live
    @(negedge clk);
    src   = '0;
    rst_n = 1'b0;
    #1;
    chk("async irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus.Addr = 2'(a);
      #1;
      chk($sformatf("async dout a%0d", a), bus.Dout, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.Addr = 2'd0;
    #1;
    chk("post rst mask", bus.Dout, 32'h0);

    // W1C racing a new edge on the same bit
    step(1, 0, 32'h3F, 6'h00, 0);
    chk("cc mask", bus.Dout, 32'h3F);
    step(1, 1, 32'h01, 6'h00, 1);
    chk("cc mode", bus.Dout, 32'h01);
    step(0, 0, 0, 6'h01, 2);
    chk("cc edge set", bus.Dout, 32'h01);
    step(0, 0, 0, 6'h00, 2);
    chk("cc edge hold", bus.Dout, 32'h01);
    step(1, 2, 32'h01, 6'h01, 2);
    chk("w1c vs edge", bus.Dout, 32'h01);
    step(1, 2, 32'h01, 6'h01, 2);
    chk("w1c clear", bus.Dout, 32'h00);

    // CLAIM+EOI in one write
    step(1, 1, 32'h00, 6'h00, 2);
    chk("cc level pend", bus.Dout, 32'h00);
    step(0, 0, 0, 6'h10, 3);
    step(1, 3, 32'h1, 6'h10, 3);
    chk("cc claim4", bus.Dout, 32'h80040010);
    step(0, 0, 0, 6'h12, 3);
    chk("cc vec1", bus.Dout, 32'h80010010);
    step(1, 3, 32'h3, 6'h12, 3);
    chk("claim eoi", bus.Dout, 32'h80010002);

    // CLAIM without valid, EOI on empty INS
    step(0, 0, 0, 6'h00, 3);
    chk("cc idle", bus.Dout, 32'h00000002);
    step(1, 3, 32'h1, 6'h00, 3);
    chk("claim novalid", bus.Dout, 32'h00000002);
    step(1, 3, 32'h2, 6'h00, 3);
    chk("eoi last", bus.Dout, 32'h00000000);
    step(1, 3, 32'h2, 6'h00, 3);
    chk("eoi empty", bus.Dout, 32'h00000000);
    chk("end irq", {31'b0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Prioritised interrupt controller between the peripheral interrupt sources (Timer0 IRQ, Timer1 IRQ, the external interrupt pin, spares) and the CPU's HWInt input.
- Latches source requests as level or edge, masks them and picks the highest-priority pending source.
- Tracks nested in-service state and drives a single request line plus vector to the CPU.
- Mapped behind the Bridge as one more device with its own WE select.

Parameters:
- N_SRC, 6, number of interrupt sources; index 0 has the highest priority, index N_SRC-1 the lowest; legal range 1..16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- Addr  in  2  word select, driven from PrAddr[3:2].
- WE  in  1  register write strobe, decoded by the Bridge.
- Din  in  32  write data.
- Dout  out  32  read data; combinational from Addr; reads have no side effects.
- src  in  N_SRC  raw interrupt request lines.
- irq  out  1  request to the CPU, registered.
- vec  out  4  index of the highest-priority pending-enabled source, combinational; 0 when none.

Behaviour:
- Registers (Addr):
  - 0 MASK: RW, bits [N_SRC-1:0] enable sources; reset 0.
  - 1 MODE: RW, 1 = edge (rising), 0 = level; reset 0.
  - 2 PEND: read returns the pending vector. Writing 1 to a bit clears an edge-mode pending bit; level-mode bits ignore writes.
  - 3 CMD/STAT:
    - Read layout: [31] valid, [19:16] vec, [15:0] in-service vector (INS).
    - Write Din[1] = EOI: clears the lowest-index set INS bit.
    - Write Din[0] = CLAIM: if valid, sets INS[vec] and, for an edge-mode vec, clears PEND[vec].
  - Unused/upper bits read 0.
- Edge detect: src_d registered each cycle. Edge pending sets on src & ~src_d; it stays set until CLAIM or a W1C write. Set wins over a same-cycle clear.
- Level pending: PEND bit equals src each cycle, registered with 1-cycle latency.
- Masking:
  - eff = PEND & MASK.
  - vec = lowest set index of eff; valid = |eff.
  - A masked source still latches pending.
- Preemption:
  - cur = lowest set INS index, or N_SRC if INS is empty.
  - Next-cycle irq = valid && (vec < cur).
  - irq deasserts the cycle after the condition fails.
  - irq is not asserted for a source equal to or lower in priority than the one in service.
- CLAIM with valid = 0: no effect.
- CLAIM and EOI in the same write:
  - EOI is evaluated on the old INS, then CLAIM sets INS[vec].
  - vec is computed before the write.
- EOI with INS empty: no effect.
- Register write and source edge in the same cycle: the register write applies, then the edge set is OR-ed in.
- Reset (reset = 0, asynchronous): MASK = MODE = PEND = INS = src_d = 0, irq = 0. src_d = 0 means a source already high at reset release reports an edge on the first cycle after release.
- Latency: source edge to irq high = 2 clk edges (pend register, then irq register).

Test Plan:
- Reset check: reset = 0 mid-run with PEND/INS nonzero -> irq, Dout at all Addr read 0 with no clk edge; after release, MASK reads 0x0.
- Level source: MASK = 0x3F, MODE = 0, src[2] = 1 -> irq = 1 two edges later, vec = 2.
  - CLAIM -> irq = 0 next cycle; STAT = 0x8002_0004.
  - EOI with src[2] still high -> irq returns.
- Edge source: MODE = 0x01, pulse src[0] for 1 cycle -> PEND = 0x01, stays set.
  - CLAIM -> PEND = 0, INS = 0x01.
  - Second pulse during service -> PEND = 0x01, irq stays 0 (equal priority).
- Nesting: claim src[3] (INS = 0x08); raise src[1] -> irq = 1; claim -> INS = 0x0A.
  - EOI -> INS = 0x08.
  - EOI -> INS = 0.
- Masking: MASK = 0x02, src = 0x05 level -> valid = 0, irq = 0, PEND = 0x05.
  - Set MASK = 0x05 -> vec = 0, irq = 1.
- Corner cases:
  - W1C on PEND bit 0 in the same cycle as a new edge on src[0] -> PEND bit 0 remains 1.
  - CLAIM + EOI (Din = 3) with INS = 0x10 and vec = 1 -> INS = 0x02.
